// File: rtl/lsu_pkg.sv
// Shared definitions for the data_mem_lsu block.
//   - RISC-V funct3 size/sign codes used by loads and stores
//   - FSM state encoding (IDLE, WAIT)
//   - lane_decode(): byte-enable mask, misalignment and illegal-code flags
//     derived from store/load direction, funct3 and the low address bits
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } lsu_state_e;

  typedef struct packed {
    logic [3:0] be;          // little-endian byte lanes touched
    logic       misaligned;
    logic       illegal;     // funct3 not defined for this direction
  } lane_info_t;

  function automatic lane_info_t lane_decode(input logic       we,
                                             input logic [2:0] funct3,
                                             input logic [1:0] addr_lo);
    lane_info_t info;
    info.be         = 4'b0000;
    info.misaligned = 1'b0;
    info.illegal    = 1'b0;
    case (funct3)
      F3_B, F3_BU: begin
        info.be      = 4'b0001 << addr_lo;
        // Unsigned variants only exist for loads.
        info.illegal = we && (funct3 == F3_BU);
      end
      F3_H, F3_HU: begin
        info.be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        info.misaligned = addr_lo[0];
        info.illegal    = we && (funct3 == F3_HU);
      end
      F3_W: begin
        info.be         = 4'b1111;
        info.misaligned = (addr_lo != 2'b00);
      end
      default: info.illegal = 1'b1;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/data_mem_lsu_if.sv
// Request/response bundle between the execute stage (master) and the
// data_mem_lsu block (slave).
//   req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata : request channel
//   rsp_valid/rsp_rdata/rsp_err                              : response strobe
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both high; the master must hold req_valid and all req_*
// fields stable until that edge and must not rely on buffering. rsp_valid is
// a single-cycle strobe with no back-pressure; rsp_rdata/rsp_err hold their
// last value until the next strobe.
interface data_mem_lsu_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_ram.sv
// Word-organised RAM with per-byte write enables.
//   clk   : write clock (rising edge)
//   we    : write strobe, be selects the byte lanes written
//   addr  : word index shared by read and write
//   wdata : lane-aligned write data
//   rdata : combinational read of mem[addr]
// Contents are intentionally not reset.
module data_mem_ram #(
  parameter  int DEPTH_WORDS = 256,
  localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_lsu.sv
// Load/store unit in front of a byte-enabled data RAM.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : data_mem_lsu_if slave (request channel + response strobe)
//   state_dbg  : current FSM state
// One transaction in flight. Stores commit on the acceptance edge; loads
// capture the addressed word on the acceptance edge and the extended result
// is presented READ_LATENCY edges later.
module data_mem_lsu
  import lsu_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DEPTH_WORDS  = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter int                    READ_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  data_mem_lsu_if.slave        bus,
  output lsu_state_e           state_dbg
);

  localparam int                  IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_WIDTH:0] SPAN     = (ADDR_WIDTH+1)'(DEPTH_WORDS * 4);
  localparam logic [1:0]          CNT_INIT = 2'(READ_LATENCY - 1);

  lsu_state_e state_q, state_d;
  logic       accept, done;
  logic [1:0] cnt_q;

  // Request decode (valid only while a request is presented).
  logic [ADDR_WIDTH-1:0] off;
  logic                  out_of_range;
  lane_info_t            lane;
  logic                  req_err;
  logic [IDX_W-1:0]      word_idx;
  logic [31:0]           wdata_rep;
  logic [31:0]           ram_rdata;

  assign off          = bus.req_addr - BASE_ADDR;
  assign out_of_range = (bus.req_addr < BASE_ADDR) || ({1'b0, off} >= SPAN);
  assign lane         = lane_decode(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);
  assign req_err      = out_of_range | lane.misaligned | lane.illegal;
  assign word_idx     = off[IDX_W+1:2];

  // Replicate the right-aligned store data into every lane; be picks lanes.
  always_comb begin
    wdata_rep = bus.req_wdata;
    case (bus.req_funct3)
      F3_B:    wdata_rep = {4{bus.req_wdata[7:0]}};
      F3_H:    wdata_rep = {2{bus.req_wdata[15:0]}};
      default: wdata_rep = bus.req_wdata;
    endcase
  end

  data_mem_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk   (clk),
    .we    (accept & bus.req_we & ~req_err),
    .be    (lane.be),
    .addr  (word_idx),
    .wdata (wdata_rep),
    .rdata (ram_rdata)
  );

  // FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          accept  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready = (state_q == IDLE);
  assign state_dbg     = state_q;

  // Captured transaction and latency counter.
  logic [31:0] rd_word_q;
  logic [2:0]  f3_q;
  logic [1:0]  lo_q;
  logic        we_q, err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= 2'd0;
      rd_word_q <= '0;
      f3_q      <= '0;
      lo_q      <= '0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
    end else if (accept) begin
      cnt_q     <= CNT_INIT;
      rd_word_q <= ram_rdata;
      f3_q      <= bus.req_funct3;
      lo_q      <= bus.req_addr[1:0];
      we_q      <= bus.req_we;
      err_q     <= req_err;
    end else if (state_q == WAIT && cnt_q != 2'd0) begin
      cnt_q <= cnt_q - 2'd1;
    end
  end

  // Lane select and sign/zero extension of the captured word.
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  always_comb begin
    case (lo_q)
      2'd0:    byte_sel = rd_word_q[7:0];
      2'd1:    byte_sel = rd_word_q[15:8];
      2'd2:    byte_sel = rd_word_q[23:16];
      default: byte_sel = rd_word_q[31:24];
    endcase
    half_sel = lo_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];
    case (f3_q)
      F3_B:    load_ext = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_ext = {24'd0, byte_sel};
      F3_H:    load_ext = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_ext = {16'd0, half_sel};
      default: load_ext = rd_word_q;
    endcase
  end

  // Response registers; data/err hold between strobes.
  logic        rsp_valid_q, rsp_err_q;
  logic [31:0] rsp_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= done;
      if (done) begin
        rsp_err_q   <= err_q;
        rsp_rdata_q <= (err_q | we_q) ? 32'd0 : load_ext;
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
module tb_data_mem_lsu;
  import lsu_pkg::*;

  logic clk;
  logic rst_n;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  data_mem_lsu_if #(.ADDR_WIDTH(32)) bus1 ();
  data_mem_lsu_if #(.ADDR_WIDTH(32)) bus2 ();
  lsu_state_e st1, st2;

  data_mem_lsu #(.ADDR_WIDTH(32), .DEPTH_WORDS(256), .BASE_ADDR(32'h0),
                 .READ_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .state_dbg(st1));

  data_mem_lsu #(.ADDR_WIDTH(32), .DEPTH_WORDS(256), .BASE_ADDR(32'h0),
                 .READ_LATENCY(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .state_dbg(st2));

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboards: {err, rdata} plus the edge number of acceptance.
  logic [32:0] exp1_q[$];
  int          acc1_q[$];
  logic [32:0] exp2_q[$];
  int          acc2_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor for the latency-1 instance
  always @(negedge clk) begin
    logic [32:0] e;
    int          a;
    if (rst_n && bus1.rsp_valid) begin
      tests++;
      if (exp1_q.size() == 0) begin
        fails++;
        $display("FAIL rsp1_unexpected: got rdata=%h err=%b expected no response",
                 bus1.rsp_rdata, bus1.rsp_err);
      end else begin
        e = exp1_q.pop_front();
        a = acc1_q.pop_front();
        if ({bus1.rsp_err, bus1.rsp_rdata} !== e || (cyc - a) != 1) begin
          fails++;
          $display("FAIL rsp1: got rdata=%h err=%b lat=%0d expected rdata=%h err=%b lat=1",
                   bus1.rsp_rdata, bus1.rsp_err, cyc - a, e[31:0], e[32]);
        end
      end
    end
  end

  // Monitor for the latency-3 instance
  always @(negedge clk) begin
    logic [32:0] e;
    int          a;
    if (rst_n && bus2.rsp_valid) begin
      tests++;
      if (exp2_q.size() == 0) begin
        fails++;
        $display("FAIL rsp2_unexpected: got rdata=%h err=%b expected no response",
                 bus2.rsp_rdata, bus2.rsp_err);
      end else begin
        e = exp2_q.pop_front();
        a = acc2_q.pop_front();
        if ({bus2.rsp_err, bus2.rsp_rdata} !== e || (cyc - a) != 3) begin
          fails++;
          $display("FAIL rsp2: got rdata=%h err=%b lat=%0d expected rdata=%h err=%b lat=3",
                   bus2.rsp_rdata, bus2.rsp_err, cyc - a, e[31:0], e[32]);
        end
      end
    end
  end

  // Driver: present one request to dut1, wait for acceptance, optionally
  // record the expected response.
  task automatic issue1(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input bit track);
    int waited;
    @(negedge clk);
    bus1.req_we     = we;
    bus1.req_funct3 = f3;
    bus1.req_addr   = addr;
    bus1.req_wdata  = wdata;
    bus1.req_valid  = 1'b1;
    waited = 0;
    while (!bus1.req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!bus1.req_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got ready=0 for addr %h expected ready=1", addr);
      bus1.req_valid = 1'b0;
      return;
    end
    if (track) begin
      exp1_q.push_back({exp_err, exp_rdata});
      acc1_q.push_back(cyc + 1);
    end
    @(posedge clk);
    #1;
    bus1.req_valid = 1'b0;
    check("ready_in_wait", {31'd0, bus1.req_ready}, 32'd0);
  endtask

  // Held-request stream for dut2
  logic        t_we   [3] = '{1'b1, 1'b0, 1'b0};
  logic [2:0]  t_f3   [3] = '{F3_W, F3_W, F3_H};
  logic [31:0] t_addr [3] = '{32'h10, 32'h10, 32'h12};
  logic [31:0] t_wd   [3] = '{32'h11223344, 32'h0, 32'h0};
  logic [31:0] t_exp  [3] = '{32'h0, 32'h11223344, 32'h00001122};

  initial begin
    logic [11:0] ready_log;
    int          idx;
    int          waited;

    rst_n = 1'b0;
    bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_funct3 = '0;
    bus1.req_addr = '0; bus1.req_wdata = '0;
    bus2.req_valid = 1'b0; bus2.req_we = 1'b0; bus2.req_funct3 = '0;
    bus2.req_addr = '0; bus2.req_wdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_ready",     {31'd0, bus1.req_ready}, 32'd1);
    check("reset_rsp_valid", {31'd0, bus1.rsp_valid}, 32'd0);
    check("reset_rsp_rdata", bus1.rsp_rdata, 32'd0);
    check("reset_rsp_err",   {31'd0, bus1.rsp_err}, 32'd0);
    check("reset_state",     {31'd0, st1}, {31'd0, IDLE});

    // Basic store / load
    issue1(1, F3_W, 32'h0, 32'hABCDEF01, 32'h0,        0, 1);
    issue1(0, F3_W, 32'h0, 32'h0,        32'hABCDEF01, 0, 1);
    // Byte store and extension
    issue1(1, F3_W,  32'h4, 32'h0,        32'h0,        0, 1);
    issue1(1, F3_B,  32'h5, 32'hAAAAAA80, 32'h0,        0, 1);
    issue1(0, F3_B,  32'h5, 32'h0,        32'hFFFFFF80, 0, 1);
    issue1(0, F3_BU, 32'h5, 32'h0,        32'h00000080, 0, 1);
    issue1(0, F3_W,  32'h4, 32'h0,        32'h00008000, 0, 1);
    // Half store and extension
    issue1(1, F3_H,  32'h2, 32'h00001234, 32'h0,        0, 1);
    issue1(0, F3_W,  32'h0, 32'h0,        32'h1234EF01, 0, 1);
    issue1(0, F3_H,  32'h2, 32'h0,        32'h00001234, 0, 1);
    issue1(0, F3_HU, 32'h0, 32'h0,        32'h0000EF01, 0, 1);
    issue1(0, F3_H,  32'h0, 32'h0,        32'hFFFFEF01, 0, 1);
    issue1(0, F3_B,  32'h3, 32'h0,        32'h00000012, 0, 1);
    issue1(0, F3_BU, 32'h1, 32'h0,        32'h000000EF, 0, 1);
    issue1(0, F3_B,  32'h1, 32'h0,        32'hFFFFFFEF, 0, 1);
    // Errors: misaligned, out of range, illegal funct3
    issue1(0, F3_W,   32'h2,   32'h0,        32'h0, 1, 1);
    issue1(1, F3_H,   32'h1,   32'h0000FFFF, 32'h0, 1, 1);
    issue1(0, F3_W,   32'h400, 32'h0,        32'h0, 1, 1);
    issue1(0, 3'b011, 32'h0,   32'h0,        32'h0, 1, 1);
    issue1(1, F3_W,   32'h400, 32'hFFFFFFFF, 32'h0, 1, 1);
    issue1(1, F3_BU,  32'h0,   32'h000000FF, 32'h0, 1, 1);
    issue1(0, F3_W,   32'h0,   32'h0,        32'h1234EF01, 0, 1);
    // Last word of the array
    issue1(1, F3_W,  32'h3FC, 32'hCAFEF00D, 32'h0,        0, 1);
    issue1(0, F3_W,  32'h3FC, 32'h0,        32'hCAFEF00D, 0, 1);
    issue1(1, F3_B,  32'h3FF, 32'h12345677, 32'h0,        0, 1);
    issue1(0, F3_BU, 32'h3FF, 32'h0,        32'h00000077, 0, 1);
    issue1(0, F3_W,  32'h3FC, 32'h0,        32'h77FEF00D, 0, 1);
    repeat (3) @(negedge clk);
    check("hold_rsp_valid", {31'd0, bus1.rsp_valid}, 32'd0);
    check("hold_rsp_rdata", bus1.rsp_rdata, 32'h77FEF00D);

    // Reset while a load is waiting
    issue1(1, F3_W, 32'h8, 32'h5A5A5A5A, 32'h0, 0, 1);
    issue1(0, F3_W, 32'h8, 32'h0,        32'h0, 0, 0);
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rst_rsp_valid", {31'd0, bus1.rsp_valid}, 32'd0);
    end
    rst_n = 1'b1;
    #1;
    check("rst_release_ready", {31'd0, bus1.req_ready}, 32'd1);
    @(negedge clk);
    check("rst_release_no_rsp", {31'd0, bus1.rsp_valid}, 32'd0);
    issue1(0, F3_W, 32'h8, 32'h0, 32'h5A5A5A5A, 0, 1);

    // Latency-3 instance: request held high across WAIT
    idx = 0;
    ready_log = '0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      ready_log[k] = bus2.req_ready;
      if (bus2.req_ready && idx < 3) begin
        bus2.req_we     = t_we[idx];
        bus2.req_funct3 = t_f3[idx];
        bus2.req_addr   = t_addr[idx];
        bus2.req_wdata  = t_wd[idx];
        bus2.req_valid  = 1'b1;
        exp2_q.push_back({1'b0, t_exp[idx]});
        acc2_q.push_back(cyc + 1);
        idx++;
      end
    end
    @(negedge clk);
    bus2.req_valid = 1'b0;
    check("l3_ready_pattern", {20'd0, ready_log}, {20'd0, 12'b0001_0001_0001});

    // Drain
    waited = 0;
    while ((exp1_q.size() != 0 || exp2_q.size() != 0) && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("drain_pending", exp1_q.size() + exp2_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
